// File: rtl/chip8_timer_ctrl_pkg.sv
// Shared definitions for the CHIP-8 delay/sound timer block: widths, write selects,
// default tone divider and the tone FSM state type.
package chip8_timer_ctrl_pkg;

    localparam int CLOCK_SPEED = 25_000_000;
    localparam int TIMER_W     = 8;

    localparam logic TIMER_SEL_DELAY = 1'b0;
    localparam logic TIMER_SEL_SOUND = 1'b1;

    // Half-period of a ~440 Hz tone at CLOCK_SPEED
    localparam int TONE_DIV_DEFAULT = CLOCK_SPEED / (2 * 440);

    typedef enum logic {
        TONE_SILENT = 1'b0,
        TONE_ON     = 1'b1
    } tone_state_t;

    function automatic logic [TIMER_W-1:0] sat_dec(input logic [TIMER_W-1:0] v);
        return (v == '0) ? v : v - TIMER_W'(1);
    endfunction

endpackage

// File: rtl/chip8_timer_ctrl_if.sv
// CPU / tick-generator / audio side signals of the timer block.
// The master drives ticks, pause and writes; the slave (timer block) drives the results.
interface chip8_timer_ctrl_if;
    import chip8_timer_ctrl_pkg::*;

    logic               tick_60hz;
    logic               pause;
    logic               wr_en;
    logic               wr_sel;
    logic [TIMER_W-1:0] wr_data;
    logic [TIMER_W-1:0] rd_delay;
    logic [TIMER_W-1:0] rd_sound;
    logic               sound_active;
    logic               delay_expired;
    logic               buzzer;

    modport master (
        output tick_60hz, pause, wr_en, wr_sel, wr_data,
        input  rd_delay, rd_sound, sound_active, delay_expired, buzzer
    );

    modport slave (
        input  tick_60hz, pause, wr_en, wr_sel, wr_data,
        output rd_delay, rd_sound, sound_active, delay_expired, buzzer
    );

endinterface

// File: rtl/chip8_tone_gen.sv
// Square-wave buzzer generator: SILENT/TONE FSM with a half-period counter.
// Phase follows enable with no lag; the buzzer output is phase registered one clk later.
module chip8_tone_gen
    import chip8_timer_ctrl_pkg::*;
#(
    parameter int TONE_DIV = TONE_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic buzzer
);

    localparam int CNT_W = $clog2(TONE_DIV);

    tone_state_t      r_state;
    tone_state_t      w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_phase;
    logic             w_phase_nxt;
    logic             r_buzzer;
    logic             w_buzzer_nxt;
    logic             w_wrap;

    assign w_wrap = (int'(r_cnt) == TONE_DIV - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= TONE_SILENT;
            r_cnt    <= '0;
            r_phase  <= 1'b0;
            r_buzzer <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_phase  <= w_phase_nxt;
            r_buzzer <= w_buzzer_nxt;
        end
    end

    // Dropping enable clears counter and phase so the next tone starts with a full low half
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = '0;
        w_phase_nxt  = 1'b0;
        w_buzzer_nxt = 1'b0;
        case (r_state)
            TONE_SILENT: begin
                if (enable) begin
                    w_state_nxt = TONE_ON;
                    w_cnt_nxt   = w_wrap ? '0 : r_cnt + CNT_W'(1);
                    w_phase_nxt = r_phase ^ w_wrap;
                end
            end
            TONE_ON: begin
                if (enable) begin
                    w_cnt_nxt    = w_wrap ? '0 : r_cnt + CNT_W'(1);
                    w_phase_nxt  = r_phase ^ w_wrap;
                    w_buzzer_nxt = r_phase;
                end else begin
                    w_state_nxt = TONE_SILENT;
                end
            end
            default: w_state_nxt = TONE_SILENT;
        endcase
    end

    assign buzzer = r_buzzer;

endmodule

// File: rtl/chip8_timer_ctrl.sv
// CHIP-8 delay and sound timers: CPU write vs 60 Hz decrement arbitration,
// DT expiry pulse, and the buzzer driven while ST is audible.
module chip8_timer_ctrl
    import chip8_timer_ctrl_pkg::*;
#(
    parameter int TONE_DIV  = TONE_DIV_DEFAULT,
    parameter int SOUND_MIN = 1
) (
    input  logic               clk,
    input  logic               rst,
    chip8_timer_ctrl_if.slave  bus
);

    logic [TIMER_W-1:0] r_dt;
    logic [TIMER_W-1:0] r_st;
    logic [TIMER_W-1:0] w_dt_nxt;
    logic [TIMER_W-1:0] w_st_nxt;
    logic               r_expired;
    logic               w_expired_nxt;
    logic               w_tick_ok;
    logic               w_wr_dt;
    logic               w_wr_st;
    logic               w_sound_active;
    logic               w_buzzer;

    assign w_tick_ok = bus.tick_60hz & ~bus.pause;
    assign w_wr_dt   = bus.wr_en & (bus.wr_sel == TIMER_SEL_DELAY);
    assign w_wr_st   = bus.wr_en & (bus.wr_sel == TIMER_SEL_SOUND);

    // A write to one register swallows that register's tick only
    always_comb begin
        w_dt_nxt = r_dt;
        w_st_nxt = r_st;
        if (w_wr_dt) begin
            w_dt_nxt = bus.wr_data;
        end else if (w_tick_ok) begin
            w_dt_nxt = sat_dec(r_dt);
        end
        if (w_wr_st) begin
            w_st_nxt = bus.wr_data;
        end else if (w_tick_ok) begin
            w_st_nxt = sat_dec(r_st);
        end
    end

    assign w_expired_nxt = ~w_wr_dt & w_tick_ok & (r_dt == TIMER_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dt      <= '0;
            r_st      <= '0;
            r_expired <= 1'b0;
        end else begin
            r_dt      <= w_dt_nxt;
            r_st      <= w_st_nxt;
            r_expired <= w_expired_nxt;
        end
    end

    assign w_sound_active = ~bus.pause & (int'(r_st) >= SOUND_MIN);

    chip8_tone_gen #(
        .TONE_DIV (TONE_DIV)
    ) u_tone (
        .clk    (clk),
        .rst    (rst),
        .enable (w_sound_active),
        .buzzer (w_buzzer)
    );

    assign bus.rd_delay      = r_dt;
    assign bus.rd_sound      = r_st;
    assign bus.sound_active  = w_sound_active;
    assign bus.delay_expired = r_expired;
    assign bus.buzzer        = w_buzzer;

endmodule

// File: tb/tb_chip8_timer_ctrl.sv
// Directed scoreboard bench for chip8_timer_ctrl: two instances (SOUND_MIN 1 and 2),
// both with a short tone divider, driven with identical stimulus.
module tb_chip8_timer_ctrl;

    localparam int S_DT_A  = 0;
    localparam int S_ST_A  = 1;
    localparam int S_SA_A  = 2;
    localparam int S_EXP_A = 3;
    localparam int S_BZ_A  = 4;
    localparam int S_SA_B  = 5;
    localparam int S_BZ_B  = 6;
    localparam int S_ST_B  = 7;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    string      tag_q[$];
    int         sig_q[$];
    logic [7:0] val_q[$];

    chip8_timer_ctrl_if a_if ();
    chip8_timer_ctrl_if b_if ();

    chip8_timer_ctrl #(.TONE_DIV(4), .SOUND_MIN(1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if)
    );

    chip8_timer_ctrl #(.TONE_DIV(4), .SOUND_MIN(2)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] obs(input int s);
        case (s)
            S_DT_A:  return a_if.rd_delay;
            S_ST_A:  return a_if.rd_sound;
            S_SA_A:  return {7'd0, a_if.sound_active};
            S_EXP_A: return {7'd0, a_if.delay_expired};
            S_BZ_A:  return {7'd0, a_if.buzzer};
            S_SA_B:  return {7'd0, b_if.sound_active};
            S_BZ_B:  return {7'd0, b_if.buzzer};
            S_ST_B:  return b_if.rd_sound;
            default: return 8'hxx;
        endcase
    endfunction

    task automatic drive(input logic t, input logic p, input logic we,
                         input logic sel, input logic [7:0] d);
        a_if.tick_60hz = t;  b_if.tick_60hz = t;
        a_if.pause     = p;  b_if.pause     = p;
        a_if.wr_en     = we; b_if.wr_en     = we;
        a_if.wr_sel    = sel; b_if.wr_sel   = sel;
        a_if.wr_data   = d;  b_if.wr_data   = d;
    endtask

    task automatic exp_push(input string tag, input int s, input logic [7:0] v);
        tag_q.push_back(tag);
        sig_q.push_back(s);
        val_q.push_back(v);
    endtask

    task automatic flush();
        string      t;
        int         s;
        logic [7:0] v;
        logic [7:0] o;
        while (sig_q.size() > 0) begin
            t = tag_q.pop_front();
            s = sig_q.pop_front();
            v = val_q.pop_front();
            o = obs(s);
            n_tests++;
            assert (o === v) else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h", t, o, v);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        drive(0, 0, 0, 0, 8'd0);
        repeat (2) step();
        exp_push("rst_dt", S_DT_A, 8'd0);
        exp_push("rst_st", S_ST_A, 8'd0);
        exp_push("rst_sa", S_SA_A, 8'd0);
        exp_push("rst_exp", S_EXP_A, 8'd0);
        exp_push("rst_bz", S_BZ_A, 8'd0);
        exp_push("rst_bz_b", S_BZ_B, 8'd0);
        flush();
        @(negedge clk);
        rst = 1'b0;
        step();

        // DT countdown and expiry pulse
        drive(0, 0, 1, 0, 8'd3);
        exp_push("dt_load", S_DT_A, 8'd3);
        step(); flush();
        for (int i = 1; i <= 3; i++) begin
            drive(1, 0, 0, 0, 8'd0);
            exp_push("dt_count", S_DT_A, 8'(3 - i));
            exp_push("dt_exp", S_EXP_A, (i == 3) ? 8'd1 : 8'd0);
            step(); flush();
        end
        drive(0, 0, 0, 0, 8'd0);
        exp_push("exp_one_cycle", S_EXP_A, 8'd0);
        exp_push("dt_zero", S_DT_A, 8'd0);
        step(); flush();
        drive(1, 0, 0, 0, 8'd0);
        exp_push("dt_sat", S_DT_A, 8'd0);
        exp_push("exp_sat", S_EXP_A, 8'd0);
        step(); flush();
        drive(0, 0, 0, 0, 8'd0);
        exp_push("exp_idle", S_EXP_A, 8'd0);
        step(); flush();

        // Write/tick collision
        drive(0, 0, 1, 0, 8'd5); step();
        drive(0, 0, 1, 1, 8'd5); step();
        drive(1, 0, 1, 0, 8'd9);
        exp_push("coll_dt", S_DT_A, 8'd9);
        exp_push("coll_st", S_ST_A, 8'd4);
        exp_push("coll_exp", S_EXP_A, 8'd0);
        step(); flush();
        drive(0, 0, 1, 0, 8'd0);
        exp_push("wr0_dt", S_DT_A, 8'd0);
        exp_push("wr0_exp", S_EXP_A, 8'd0);
        step(); flush();
        drive(0, 0, 1, 1, 8'd0); step();
        drive(0, 0, 0, 0, 8'd0); step();
        exp_push("st0_bz", S_BZ_A, 8'd0);
        exp_push("st0_sa", S_SA_A, 8'd0);
        step(); flush();

        // Tone waveform from silence
        drive(0, 0, 1, 1, 8'd2);
        exp_push("tone_sa", S_SA_A, 8'd1);
        exp_push("tone_bz0", S_BZ_A, 8'd0);
        step(); flush();
        for (int j = 1; j <= 16; j++) begin
            drive(0, 0, 0, 0, 8'd0);
            exp_push("tone_bz", S_BZ_A, 8'(((j - 1) / 4) % 2));
            step(); flush();
        end
        drive(1, 0, 0, 0, 8'd0);
        exp_push("tone_st1", S_ST_A, 8'd1);
        exp_push("tone_sa1", S_SA_A, 8'd1);
        step(); flush();
        drive(1, 0, 0, 0, 8'd0);
        exp_push("tone_st0", S_ST_A, 8'd0);
        exp_push("tone_sa0", S_SA_A, 8'd0);
        step(); flush();
        drive(0, 0, 0, 0, 8'd0);
        exp_push("tone_off_bz", S_BZ_A, 8'd0);
        step(); flush();

        // SOUND_MIN = 2 instance
        drive(0, 0, 1, 1, 8'd1);
        exp_push("smin_sa_b", S_SA_B, 8'd0);
        exp_push("smin_st_b", S_ST_B, 8'd1);
        exp_push("smin_sa_a", S_SA_A, 8'd1);
        step(); flush();
        for (int k = 0; k < 6; k++) begin
            drive(0, 0, 0, 0, 8'd0);
            exp_push("smin_bz_b", S_BZ_B, 8'd0);
            exp_push("smin_sa_b_hold", S_SA_B, 8'd0);
            step(); flush();
        end
        drive(0, 0, 1, 1, 8'd2);
        exp_push("smin_sa_b2", S_SA_B, 8'd1);
        step(); flush();
        drive(0, 0, 1, 1, 8'd0); step();
        drive(0, 0, 0, 0, 8'd0); step();

        // Pause freezes timers and mutes, writes still land
        drive(0, 0, 1, 0, 8'd10); step();
        drive(0, 0, 1, 1, 8'd7); step();
        drive(0, 1, 0, 0, 8'd0);
        exp_push("pause_sa", S_SA_A, 8'd0);
        step(); flush();
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 0, 0, 8'd0);
            exp_push("pause_dt", S_DT_A, 8'd10);
            exp_push("pause_st", S_ST_A, 8'd7);
            exp_push("pause_bz", S_BZ_A, 8'd0);
            step(); flush();
        end
        drive(0, 1, 1, 0, 8'd20);
        exp_push("pause_wr", S_DT_A, 8'd20);
        step(); flush();
        drive(0, 0, 0, 0, 8'd0); step();
        drive(1, 0, 0, 0, 8'd0);
        exp_push("resume_dt", S_DT_A, 8'd19);
        exp_push("resume_st", S_ST_A, 8'd6);
        exp_push("resume_exp", S_EXP_A, 8'd0);
        step(); flush();
        drive(0, 0, 1, 1, 8'd0); step();
        drive(0, 0, 0, 0, 8'd0); step();
        step();

        // Async reset while the buzzer is high
        drive(0, 0, 1, 1, 8'd50); step();
        for (int j = 1; j <= 8; j++) begin
            drive(0, 0, 0, 0, 8'd0);
            exp_push("pre_rst_bz", S_BZ_A, 8'(((j - 1) / 4) % 2));
            step(); flush();
        end
        #3;
        rst = 1'b1;
        #1;
        exp_push("arst_bz", S_BZ_A, 8'd0);
        exp_push("arst_st", S_ST_A, 8'd0);
        exp_push("arst_dt", S_DT_A, 8'd0);
        exp_push("arst_sa", S_SA_A, 8'd0);
        exp_push("arst_exp", S_EXP_A, 8'd0);
        flush();
        #2;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_push("post_rst_st", S_ST_A, 8'd0);
            exp_push("post_rst_sa", S_SA_A, 8'd0);
            exp_push("post_rst_bz", S_BZ_A, 8'd0);
            step(); flush();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
